// File: rtl/vga_pkg.sv
// Shared constants for the vga_translate slave: register map, screen size
// and the box sequencer state encoding.
package vga_pkg;

    localparam int unsigned REG_X    = 0;
    localparam int unsigned REG_Y    = 1;
    localparam int unsigned REG_W    = 2;
    localparam int unsigned REG_H    = 3;
    localparam int unsigned REG_GO   = 4;
    localparam int unsigned PIX_BASE = 6;

    localparam int unsigned VGA_COLS = 640;
    localparam int unsigned VGA_ROWS = 480;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_X,
        S_WR_Y,
        S_WR_W,
        S_WR_H,
        S_WR_GO,
        S_PIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/vga_box_sequencer.sv
// Avalon-MM master that programs one vga_translate box and then streams its
// w*h pixels from a valid/ready source into the translator pixel window.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a box command (blocked while frame_hold)
// WR_X..H | writing latched x, y, w, h to translator registers 0..3
// WR_GO   | box-start write to register 4
// PIX     | one bus write per source pixel until total beats done
// DONE    | one-cycle done pulse (err on a rejected command)
module vga_box_sequencer #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16,
    parameter int PIX_BASE = vga_pkg::PIX_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_x,
    input  logic [15:0]       cmd_y,
    input  logic [15:0]       cmd_w,
    input  logic [15:0]       cmd_h,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [1:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic              frame_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import vga_pkg::*;

    state_t      state, state_n;
    logic [15:0] box_x, box_y, box_w, box_h;
    logic [31:0] total;
    logic [31:0] cnt;
    logic        err_q;

    logic [31:0] area;
    logic [32:0] area_limit;
    logic        reject;
    logic        accept;
    logic        beat;

    // The window holds 2^ADDR_W - PIX_BASE words; larger boxes would wrap.
    assign area       = cmd_w * cmd_h;
    assign area_limit = (33'd1 << ADDR_W) - 33'(PIX_BASE);
    assign reject     = (cmd_w == 16'd0) || (cmd_h == 16'd0) || ({1'b0, area} > area_limit);
    assign accept     = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign beat       = (state == S_PIX) && pix_valid && !avm_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            total <= '0;
            box_x <= '0;
            box_y <= '0;
            box_w <= '0;
            box_h <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                box_x <= cmd_x;
                box_y <= cmd_y;
                box_w <= cmd_w;
                box_h <= cmd_h;
                total <= area;
                err_q <= reject;
            end
            if (beat) begin
                cnt <= cnt + 32'd1;
            end else if (state == S_DONE) begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_n       = state;
        cmd_ready     = 1'b0;
        pix_ready     = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        busy          = 1'b1;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = !frame_hold;
                if (cmd_valid && !frame_hold) begin
                    state_n = reject ? S_DONE : S_WR_X;
                end
            end
            S_WR_X: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_W'(REG_X);
                avm_writedata = DATA_W'(box_x);
                if (!avm_waitrequest) state_n = S_WR_Y;
            end
            S_WR_Y: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_W'(REG_Y);
                avm_writedata = DATA_W'(box_y);
                if (!avm_waitrequest) state_n = S_WR_W;
            end
            S_WR_W: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_W'(REG_W);
                avm_writedata = DATA_W'(box_w);
                if (!avm_waitrequest) state_n = S_WR_H;
            end
            S_WR_H: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_W'(REG_H);
                avm_writedata = DATA_W'(box_h);
                if (!avm_waitrequest) state_n = S_WR_GO;
            end
            S_WR_GO: begin
                avm_write   = 1'b1;
                avm_address = ADDR_W'(REG_GO);
                if (!avm_waitrequest) state_n = S_PIX;
            end
            S_PIX: begin
                avm_write     = pix_valid;
                avm_address   = ADDR_W'(PIX_BASE) + cnt[ADDR_W-1:0];
                avm_writedata = pix_data;
                pix_ready     = !avm_waitrequest;
                if (beat && (cnt == total - 32'd1)) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign avm_byteenable = avm_write ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_vga_box_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus writes and done pulses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vga_box_sequencer;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int cyc;
        bit err;
    } dn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [15:0] pix_data = '0;
    logic [18:0] avm_address;
    logic        avm_write;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic        frame_hold = 1'b0;
    logic        busy, done, err;

    vga_box_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .frame_hold(frame_hold),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cnt = 0;
    int  last_t = 0;
    bit  mon_en = 1'b0;
    bit  stall_en = 1'b0;
    int  st2 = 0, st9 = 0;
    wr_t wq[$];
    dn_t dq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Slave model: three-cycle stall on words 2 and 9 when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall_en && avm_write && avm_address == 19'd2 && st2 < 3) begin
                avm_waitrequest = 1'b1;
                st2++;
            end else if (stall_en && avm_write && avm_address == 19'd9 && st9 < 3) begin
                avm_waitrequest = 1'b1;
                st9++;
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    bit          prev_stall = 1'b0;
    logic [18:0] prev_addr;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            chk("byteenable", avm_byteenable, avm_write ? 2'b11 : 2'b00);
            if (prev_stall) begin
                chk("stall_addr_stable", avm_address, prev_addr);
                chk("stall_data_stable", avm_writedata, prev_data);
            end
            if (avm_write && !avm_waitrequest) begin
                if (wq.size() == 0) begin
                    flag("unexpected_write", $sformatf("addr %0d data %0h", avm_address, avm_writedata));
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write_addr", avm_address, e.addr);
                    chk("write_data", avm_writedata, e.data);
                end
            end
            if (pix_ready) chk("write_follows_valid", avm_write, pix_valid);
            if (done) begin
                done_cnt++;
                if (dq.size() == 0) begin
                    flag("unexpected_done", "done with nothing expected");
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
                    chk("err_flag", err, d.err);
                end
            end else if (err) begin
                flag("err_without_done", "err high while done low");
            end
            prev_stall = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end
    end

    // done_off: >=0 done expected at accept+done_off, -1 any time, -2 none.
    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input int done_off, input bit rej);
        bit ok;
        ok = 1'b0;
        cmd_x = 16'(x); cmd_y = 16'(y); cmd_w = 16'(w); cmd_h = 16'(h);
        cmd_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                last_t = cyc;
                if (done_off != -2) dq.push_back('{cyc: (done_off >= 0) ? cyc + done_off : -1, err: rej});
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) flag("cmd_accept_timeout", "cmd_ready never seen");
    endtask

    task automatic feed_pix(input int n, input int base, input bit toggle,
                            input int hold_after, input int reset_after);
        int  idx;
        bit  ph;
        bit  beat;
        bit  stop;
        idx = 0; ph = 1'b1; stop = 1'b0;
        for (int loops = 0; loops < 400 && idx < n && !stop; loops++) begin
            pix_valid = toggle ? ph : 1'b1;
            pix_data  = 16'(base + idx);
            @(negedge clk);
            beat = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            ph = ~ph;
            if (beat) begin
                idx++;
                if (idx == hold_after) frame_hold = 1'b1;
                if (idx == reset_after) begin
                    pix_valid = 1'b0;
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    @(negedge clk);
                    chk("write_low_after_reset", avm_write, 1'b0);
                    chk("idle_after_reset", busy, 1'b0);
                    stop = 1'b1;
                end
            end
        end
        pix_valid = 1'b0;
        if (idx < n && !stop) flag("pixel_timeout", $sformatf("only %0d of %0d pixels taken", idx, n));
    endtask

    task automatic run_box(input int x, input int y, input int w, input int h, input int base,
                           input bit toggle, input int hold_after, input int reset_after,
                           input int done_off);
        int n;
        int d0;
        bit seen;
        @(posedge clk);
        #1;
        wq.push_back('{addr: 0, data: x});
        wq.push_back('{addr: 1, data: y});
        wq.push_back('{addr: 2, data: w});
        wq.push_back('{addr: 3, data: h});
        wq.push_back('{addr: 4, data: 0});
        n = (reset_after > 0) ? reset_after : w * h;
        for (int i = 0; i < n; i++) wq.push_back('{addr: 6 + i, data: (base + i) & 16'hffff});
        d0 = done_cnt;
        fork
            send_cmd(x, y, w, h, (reset_after > 0) ? -2 : done_off, 1'b0);
            feed_pix(w * h, base, toggle, hold_after, reset_after);
        join
        if (reset_after == 0) begin
            seen = 1'b0;
            for (int k = 0; k < 300 && !seen; k++) begin
                @(negedge clk);
                if (done_cnt != d0) seen = 1'b1;
            end
            if (!seen) flag("done_timeout", "box never completed");
        end
        repeat (2) @(negedge clk);
        chk("writes_drained", wq.size(), 0);
    endtask

    task automatic run_reject(input int w, input int h);
        @(posedge clk);
        #1;
        send_cmd(7, 9, w, h, 1, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("cmd_ready_after_reject", cmd_ready, 1'b1);
        chk("reject_no_writes", wq.size(), 0);
    endtask

    initial begin
        int rel;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_avm_write", avm_write, 1'b0);
        chk("rst_avm_address", avm_address, 19'd0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        mon_en = 1'b1;

        run_box(10, 20, 4, 2, 1, 1'b0, 0, 0, 14);

        st2 = 0; st9 = 0; stall_en = 1'b1;
        run_box(10, 20, 4, 2, 1, 1'b0, 0, 0, 20);
        stall_en = 1'b0;
        chk("stall_cycles_applied", st2 + st9, 6);

        run_box(10, 20, 4, 2, 16'h0011, 1'b1, 0, 0, -1);

        run_reject(0, 5);
        run_reject(1024, 1024);

        @(posedge clk);
        #1;
        frame_hold = 1'b1;
        cmd_valid = 1'b1; cmd_w = 16'd1; cmd_h = 16'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_no_write", avm_write, 1'b0);
            chk("hold_not_busy", busy, 1'b0);
            @(posedge clk);
            #1;
        end
        frame_hold = 1'b0;
        cmd_valid = 1'b0;
        rel = cyc + 1;
        run_box(30, 40, 4, 2, 16'h0100, 1'b0, 2, 0, 14);
        chk("accept_after_release", last_t, rel);
        frame_hold = 1'b0;

        run_box(10, 20, 4, 2, 16'h0200, 1'b0, 0, 3, 0);
        run_box(3, 5, 1, 1, 16'haaaa, 1'b0, 0, 0, 7);

        chk("done_queue_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
